// File: rtl/stopwatch_tick_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_tick_ctrl
//
// Upstream control stage for the stopwatch counter chain. Two raw, bouncing
// push-buttons are synchronised and debounced into one-cycle press events.
// Those events drive an IDLE/RUN/PAUSE state machine. A prescaler produces a
// one-cycle tick every CLK_DIV clocks while running. A one-cycle clear pulse
// resets the downstream counter.
//
// Parameters
//   CLK_DIV   clock cycles per tick (>= 1)
//   DEBOUNCE  consecutive differing cycles needed to accept a level change (>= 1)
//
// Ports
//   clk             in   system clock, rising edge
//   reset           in   asynchronous, active-high; clears all state
//   btn_start_stop  in   raw start/stop button, active-high
//   btn_clear       in   raw clear button, active-high
//   tick            out  registered one-cycle pulse, counter enable
//   clear           out  registered one-cycle pulse, counter reset
//   running         out  registered, high while state is RUN
//   state           out  registered state: IDLE=00, RUN=01, PAUSE=10
// -----------------------------------------------------------------------------
module stopwatch_tick_ctrl #(
  parameter int CLK_DIV  = 100000,
  parameter int DEBOUNCE = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  output logic       tick,
  output logic       clear,
  output logic       running,
  output logic [1:0] state
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  // The flip happens on the DEBOUNCE-th differing cycle, so the counter
  // only ever has to hold values up to DEBOUNCE-1.
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10
  } state_t;

  // Bit 0 = start/stop, bit 1 = clear.
  logic [1:0] w_btn_raw;
  logic [1:0] w_press;

  assign w_btn_raw = {btn_clear, btn_start_stop};

  // ---------------------------------------------------------------------------
  // Per-button synchroniser and debouncer
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic          r_sync1;
      logic          r_sync2;
      logic          r_db;
      logic          r_press;
      logic [DW-1:0] r_db_cnt;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_sync1  <= 1'b0;
          r_sync2  <= 1'b0;
          r_db     <= 1'b0;
          r_press  <= 1'b0;
          r_db_cnt <= '0;
        end else begin
          r_sync1 <= w_btn_raw[gi];
          r_sync2 <= r_sync1;
          r_press <= 1'b0;
          if (r_sync2 == r_db) begin
            r_db_cnt <= '0;
          end else if (r_db_cnt == DB_LAST) begin
            // Accept the new level; only a rising accepted level is a press.
            r_db_cnt <= '0;
            r_db     <= r_sync2;
            r_press  <= r_sync2;
          end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
          end
        end
      end

      assign w_press[gi] = r_press;
    end
  endgenerate

  logic w_ss_press;
  logic w_clr_press;

  assign w_ss_press  = w_press[0];
  assign w_clr_press = w_press[1];

  // ---------------------------------------------------------------------------
  // State machine and prescaler
  // ---------------------------------------------------------------------------
  state_t        r_state;
  state_t        w_state_next;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_next;
  logic          r_tick;
  logic          w_tick_next;
  logic          r_clear;
  logic          w_clear_next;
  logic          r_running;
  logic          w_presc_wrap;

  assign w_presc_wrap = (r_presc == PRESC_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_presc   <= '0;
      r_tick    <= 1'b0;
      r_clear   <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_presc   <= w_presc_next;
      r_tick    <= w_tick_next;
      r_clear   <= w_clear_next;
      r_running <= (w_state_next == S_RUN);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_presc_next = r_presc;
    w_tick_next  = 1'b0;
    w_clear_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ss_press) begin
          w_state_next = S_RUN;
          w_presc_next = '0;
        end else if (w_clr_press) begin
          w_clear_next = 1'b1;
        end
      end
      S_RUN: begin
        // A terminal count still ticks even on the pausing edge; otherwise
        // pausing freezes the prescaler so the phase survives the pause.
        // Clear presses are ignored while running.
        if (w_presc_wrap) begin
          w_presc_next = '0;
          w_tick_next  = 1'b1;
        end else if (!w_ss_press) begin
          w_presc_next = r_presc + 1'b1;
        end
        if (w_ss_press) begin
          w_state_next = S_PAUSE;
        end
      end
      S_PAUSE: begin
        // start/stop has priority; a simultaneous clear is dropped.
        if (w_ss_press) begin
          w_state_next = S_RUN;
        end else if (w_clr_press) begin
          w_state_next = S_IDLE;
          w_clear_next = 1'b1;
          w_presc_next = '0;
        end
      end
      default: begin
        // Encoding 11 is unreachable; fall back to a clean IDLE.
        w_state_next = S_IDLE;
        w_presc_next = '0;
      end
    endcase
  end

  assign tick    = r_tick;
  assign clear   = r_clear;
  assign running = r_running;
  assign state   = r_state;

endmodule
